// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   MEM-stage load/store unit. Converts the EX/MEM memory-access fields into a
//   request/grant/response transaction on the data-memory port. It sign- or
//   zero-extends load data into MEM_dm_dataout, stalls the front of the
//   pipeline while an access is outstanding, and flags misaligned, illegal
//   and timed-out accesses.
// Ports
//   clk, rst                      : clock (rising edge), synchronous active-high reset
//   MEM_mem_read / MEM_mem_write  : load / store present in MEM
//   MEM_func3                     : access type (0=B 1=H 2=W 4=BU 5=HU)
//   MEM_alu_result                : byte address
//   MEM_rs2_data                  : store data
//   dm_req/we/addr/wstrb/wdata    : registered request fields to data memory
//   dm_gnt, dm_rvalid, dm_rdata   : memory grant / read response
//   MEM_dm_dataout                : extended load result (held between loads)
//   lsu_stall                     : hold IF/ID/EX/MEM registers this cycle
//   lsu_done, lsu_err             : one-cycle completion / error pulses
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_mem_read,
  input  logic        MEM_mem_write,
  input  logic [2:0]  MEM_func3,
  input  logic [31:0] MEM_alu_result,
  input  logic [31:0] MEM_rs2_data,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic [31:0] MEM_dm_dataout,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic        lsu_err
);

  localparam logic [9:0] LP_TMO = 10'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t      r_state;
  logic [9:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [2:0]  r_func3;
  logic [1:0]  r_off;
  logic [31:0] r_dout;
  logic        r_done;
  logic        r_err;

  logic        w_access;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_start_ok;
  logic        w_start_bad;
  logic        w_tmo;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_ldata;

  assign w_access = MEM_mem_read | MEM_mem_write;

  always_comb begin
    w_illegal = 1'b0;
    case (MEM_func3)
      3'd0, 3'd1, 3'd2: w_illegal = 1'b0;
      3'd4, 3'd5:       w_illegal = MEM_mem_write;   // no unsigned stores
      default:          w_illegal = 1'b1;
    endcase
  end

  // func3[1:0] gives the access size for every legal encoding.
  assign w_misalign = ((MEM_func3[1:0] == 2'b01) &  MEM_alu_result[0]) |
                      ((MEM_func3[1:0] == 2'b10) & |MEM_alu_result[1:0]);

  assign w_start_ok  = (r_state == S_IDLE) & w_access & ~(w_illegal | w_misalign);
  assign w_start_bad = (r_state == S_IDLE) & w_access &  (w_illegal | w_misalign);

  assign w_tmo = ((r_state == S_REQ) | (r_state == S_RESP)) & (r_cnt == LP_TMO);

  always_comb begin
    w_wstrb = '0;
    w_wdata = MEM_rs2_data;
    case (MEM_func3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << MEM_alu_result[1:0];
        w_wdata = {4{MEM_rs2_data[7:0]}};
      end
      2'b01: begin
        w_wstrb = MEM_alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{MEM_rs2_data[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = MEM_rs2_data;
      end
    endcase
  end

  // Bring the addressed byte/half down to bit 0, then extend.
  assign w_shifted = dm_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ldata = w_shifted;
    case (r_func3)
      3'd0:    w_ldata = {{24{w_shifted[7]}},  w_shifted[7:0]};
      3'd1:    w_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'd4:    w_ldata = {24'd0, w_shifted[7:0]};
      3'd5:    w_ldata = {16'd0, w_shifted[15:0]};
      default: w_ldata = dm_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
      r_func3 <= '0;
      r_off   <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state <= S_REQ;
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_we    <= MEM_mem_write;
            r_addr  <= {MEM_alu_result[31:2], 2'b00};
            r_wstrb <= MEM_mem_write ? w_wstrb : 4'b0000;
            r_wdata <= w_wdata;
            r_func3 <= MEM_func3;
            r_off   <= MEM_alu_result[1:0];
          end else if (w_start_bad) begin
            r_err  <= 1'b1;
            r_dout <= '0;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 10'd1;
          // A grant in the timeout cycle still completes the access.
          if (dm_gnt) begin
            r_req   <= 1'b0;
            r_state <= r_we ? S_DONE : S_RESP;
            r_done  <= r_we;
          end else if (w_tmo) begin
            r_req   <= 1'b0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_dout  <= '0;
          end
        end
        S_RESP: begin
          r_cnt <= r_cnt + 10'd1;
          if (dm_rvalid) begin
            r_dout  <= w_ldata;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_tmo) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_dout  <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dm_req         = r_req & ~w_tmo;
  assign dm_we          = r_we;
  assign dm_addr        = r_addr;
  assign dm_wstrb       = r_wstrb;
  assign dm_wdata       = r_wdata;
  assign MEM_dm_dataout = r_dout;
  assign lsu_done       = r_done;
  assign lsu_err        = r_err;
  assign lsu_stall      = (r_state == S_REQ) | (r_state == S_RESP) | w_start_ok;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_mem_read, MEM_mem_write;
  logic [2:0]  MEM_func3;
  logic [31:0] MEM_alu_result, MEM_rs2_data;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic [31:0] MEM_dm_dataout;
  logic        lsu_stall, lsu_done, lsu_err;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;

  bus_t        q_bus[$];
  logic [31:0] q_dout[$];

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .MEM_mem_read(MEM_mem_read), .MEM_mem_write(MEM_mem_write),
    .MEM_func3(MEM_func3), .MEM_alu_result(MEM_alu_result), .MEM_rs2_data(MEM_rs2_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .MEM_dm_dataout(MEM_dm_dataout), .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_err(lsu_err)
  );

  // Reference extension of a read word, written with part-selects.
  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = (off[1]) ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Drives one well-formed access; expected bus fields / load result come from the queues.
  task automatic do_access(input string nm, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2,
                           input logic [31:0] rdata, input int gw, input int rw);
    bus_t        e;
    logic [31:0] ed;
    @(negedge clk);
    MEM_mem_read = ~we; MEM_mem_write = we; MEM_func3 = f3;
    MEM_alu_result = addr; MEM_rs2_data = rs2;
    #1;
    n_chk++;
    if (lsu_stall !== 1'b1) begin n_err++; $display("FAIL %s stall_c0 got %b want 1", nm, lsu_stall); end
    @(negedge clk);
    e = q_bus.pop_front();
    n_chk++;
    if (dm_req !== 1'b1 || lsu_stall !== 1'b1) begin
      n_err++; $display("FAIL %s req_c1 req=%b stall=%b want 1/1", nm, dm_req, lsu_stall);
    end
    n_chk++;
    if (dm_we !== e.we || dm_addr !== e.addr || dm_wstrb !== e.wstrb) begin
      n_err++;
      $display("FAIL %s bus we=%b addr=%h wstrb=%b want %b %h %b", nm, dm_we, dm_addr, dm_wstrb,
               e.we, e.addr, e.wstrb);
    end
    if (e.we) begin
      n_chk++;
      if (dm_wdata !== e.wdata) begin n_err++; $display("FAIL %s wdata got %h want %h", nm, dm_wdata, e.wdata); end
    end
    for (int k = 0; k < gw; k++) begin
      @(negedge clk);
      n_chk++;
      if (dm_req !== ((k + 1) < TMO) || dm_addr !== e.addr || lsu_stall !== 1'b1) begin
        n_err++;
        $display("FAIL %s hold req=%b addr=%h stall=%b want %b %h 1", nm, dm_req, dm_addr, lsu_stall,
                 ((k + 1) < TMO), e.addr);
      end
    end
    dm_gnt = 1'b1;
    if (!we) begin dm_rvalid = 1'b1; dm_rdata = ~rdata; end
    @(negedge clk);
    dm_gnt = 1'b0; dm_rvalid = 1'b0;
    n_chk++;
    if (dm_req !== 1'b0) begin n_err++; $display("FAIL %s req_after_gnt got %b want 0", nm, dm_req); end
    if (!we) begin
      n_chk++;
      if (lsu_stall !== 1'b1 || lsu_done !== 1'b0) begin
        n_err++; $display("FAIL %s resp_wait stall=%b done=%b want 1/0", nm, lsu_stall, lsu_done);
      end
      repeat (rw) @(negedge clk);
      dm_rvalid = 1'b1; dm_rdata = rdata;
      @(negedge clk);
      dm_rvalid = 1'b0;
    end
    n_chk++;
    if (lsu_done !== 1'b1 || lsu_stall !== 1'b0 || lsu_err !== 1'b0) begin
      n_err++; $display("FAIL %s done done=%b stall=%b err=%b want 1/0/0", nm, lsu_done, lsu_stall, lsu_err);
    end
    if (!we) begin
      ed = q_dout.pop_front();
      n_chk++;
      if (MEM_dm_dataout !== ed) begin n_err++; $display("FAIL %s dataout got %h want %h", nm, MEM_dm_dataout, ed); end
    end
    MEM_mem_read = 1'b0; MEM_mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    MEM_mem_read = 0; MEM_mem_write = 0; MEM_func3 = 0; MEM_alu_result = 0; MEM_rs2_data = 0;
    dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({dm_req, dm_we, dm_wstrb, lsu_done, lsu_err, lsu_stall} !== 9'd0 ||
        dm_addr !== 32'd0 || dm_wdata !== 32'd0 || MEM_dm_dataout !== 32'd0) begin
      n_err++;
      $display("FAIL reset req=%b we=%b wstrb=%b done=%b err=%b stall=%b addr=%h wdata=%h dout=%h want all 0",
               dm_req, dm_we, dm_wstrb, lsu_done, lsu_err, lsu_stall, dm_addr, dm_wdata, MEM_dm_dataout);
    end
  endtask

  task automatic test_stores();
    q_bus.push_back('{1'b1, 32'h100, 4'b1111, 32'hDEADBEEF});
    do_access("sw", 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    q_bus.push_back('{1'b1, 32'h200, 4'b1000, 32'h78787878});
    do_access("sb", 1'b1, 3'd0, 32'h203, 32'h12345678, 32'h0, 1, 0);
    q_bus.push_back('{1'b1, 32'h300, 4'b1100, 32'hCCDDCCDD});
    do_access("sh", 1'b1, 3'd1, 32'h302, 32'hAABBCCDD, 32'h0, 2, 0);
    // Grant lands in the very cycle the counter reaches the limit: completes, no error.
    q_bus.push_back('{1'b1, 32'h400, 4'b0001, 32'h5A5A5A5A});
    do_access("sb_tmo_tie", 1'b1, 3'd0, 32'h400, 32'h0000005A, 32'h0, TMO, 0);
  endtask

  task automatic test_loads();
    q_bus.push_back('{1'b0, 32'h100, 4'b0000, 32'h0});
    q_dout.push_back(32'hFFFFFF80);
    do_access("lb", 1'b0, 3'd0, 32'h102, 32'h0, 32'h0080FF00, 0, 0);
    q_bus.push_back('{1'b0, 32'h100, 4'b0000, 32'h0});
    q_dout.push_back(32'h00000080);
    do_access("lbu", 1'b0, 3'd4, 32'h102, 32'h0, 32'h0080FF00, 0, 0);
    q_bus.push_back('{1'b0, 32'h500, 4'b0000, 32'h0});
    q_dout.push_back(32'hFFFF8001);
    do_access("lh", 1'b0, 3'd1, 32'h502, 32'h0, 32'h80011234, 1, 1);
    q_bus.push_back('{1'b0, 32'h500, 4'b0000, 32'h0});
    q_dout.push_back(32'h00008001);
    do_access("lhu", 1'b0, 3'd5, 32'h502, 32'h0, 32'h80011234, 0, 2);
    q_bus.push_back('{1'b0, 32'h600, 4'b0000, 32'h0});
    q_dout.push_back(32'hCAFEF00D);
    do_access("lw", 1'b0, 3'd2, 32'h600, 32'h0, 32'hCAFEF00D, 0, 0);
  endtask

  task automatic test_bad_access();
    // dataout is non-zero from the previous load, so the clear is observable.
    @(negedge clk);
    MEM_mem_read = 1'b1; MEM_func3 = 3'd1; MEM_alu_result = 32'h101;
    #1;
    n_chk++;
    if (lsu_stall !== 1'b0 || dm_req !== 1'b0) begin
      n_err++; $display("FAIL misalign_c0 stall=%b req=%b want 0/0", lsu_stall, dm_req);
    end
    @(negedge clk);
    MEM_mem_read = 1'b0;
    n_chk++;
    if (lsu_err !== 1'b1 || MEM_dm_dataout !== 32'd0 || dm_req !== 1'b0 || lsu_done !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_err err=%b dout=%h req=%b done=%b want 1 0 0 0", lsu_err, MEM_dm_dataout, dm_req, lsu_done);
    end
    @(negedge clk);
    n_chk++;
    if (lsu_err !== 1'b0) begin n_err++; $display("FAIL misalign_pulse err=%b want 0", lsu_err); end
    // Unsigned store encoding is illegal even when aligned.
    MEM_mem_write = 1'b1; MEM_func3 = 3'd4; MEM_alu_result = 32'h0;
    #1;
    n_chk++;
    if (lsu_stall !== 1'b0) begin n_err++; $display("FAIL illegal_c0 stall=%b want 0", lsu_stall); end
    @(negedge clk);
    MEM_mem_write = 1'b0;
    n_chk++;
    if (lsu_err !== 1'b1 || dm_req !== 1'b0) begin
      n_err++; $display("FAIL illegal_err err=%b req=%b want 1/0", lsu_err, dm_req);
    end
  endtask

  task automatic test_timeout();
    q_bus.push_back('{1'b0, 32'h700, 4'b0000, 32'h0});
    q_dout.push_back(32'h00000077);
    do_access("lw_pre", 1'b0, 3'd2, 32'h700, 32'h0, 32'h00000077, 0, 0);
    @(negedge clk);
    MEM_mem_read = 1'b1; MEM_func3 = 3'd2; MEM_alu_result = 32'h800;
    for (int k = 0; k < int'(TMO) + 1; k++) begin
      @(negedge clk);
      n_chk++;
      if (dm_req !== (k < int'(TMO)) || lsu_stall !== 1'b1) begin
        n_err++; $display("FAIL tmo_req cyc=%0d req=%b stall=%b want %b 1", k, dm_req, lsu_stall, (k < int'(TMO)));
      end
    end
    @(negedge clk);
    MEM_mem_read = 1'b0;
    n_chk++;
    if (lsu_err !== 1'b1 || MEM_dm_dataout !== 32'd0 || lsu_stall !== 1'b0 || dm_req !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_done err=%b dout=%h stall=%b req=%b want 1 0 0 0", lsu_err, MEM_dm_dataout, lsu_stall, dm_req);
    end
  endtask

  task automatic test_reset_in_resp();
    q_bus.push_back('{1'b0, 32'h900, 4'b0000, 32'h0});
    q_dout.push_back(32'h0000ABCD);
    do_access("lw_pre2", 1'b0, 3'd2, 32'h900, 32'h0, 32'h0000ABCD, 0, 0);
    @(negedge clk);
    MEM_mem_read = 1'b1; MEM_func3 = 3'd2; MEM_alu_result = 32'hA00;
    @(negedge clk);
    dm_gnt = 1'b1;
    @(negedge clk);
    dm_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; MEM_mem_read = 1'b0;
    dm_rvalid = 1'b1; dm_rdata = 32'h13572468;
    @(negedge clk);
    dm_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (lsu_done !== 1'b0 || lsu_stall !== 1'b0 || dm_req !== 1'b0 || MEM_dm_dataout !== 32'd0) begin
        n_err++;
        $display("FAIL rst_resp cyc=%0d done=%b stall=%b req=%b dout=%h want 0 0 0 0", k, lsu_done, lsu_stall,
                 dm_req, MEM_dm_dataout);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] addr, rs2, rd;
      logic [3:0]  st;
      logic [31:0] wd;
      we  = 1'($urandom_range(0, 1));
      rs2 = $urandom;
      rd  = $urandom;
      case ($urandom_range(0, we ? 2 : 4))
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd2;
        3: f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      off = 2'($urandom_range(0, 3));
      if (f3 == 3'd1 || f3 == 3'd5) off[0] = 1'b0;
      if (f3 == 3'd2) off = 2'b00;
      addr = {$urandom_range(0, 16'hFFFF), 2'b00} | {30'd0, off};
      case (f3)
        3'd0: begin st = 4'b0001 << off; wd = {rs2[7:0], rs2[7:0], rs2[7:0], rs2[7:0]}; end
        3'd1: begin st = off[1] ? 4'b1100 : 4'b0011; wd = {rs2[15:0], rs2[15:0]}; end
        default: begin st = 4'b1111; wd = rs2; end
      endcase
      if (we) q_bus.push_back('{1'b1, {addr[31:2], 2'b00}, st, wd});
      else begin
        q_bus.push_back('{1'b0, {addr[31:2], 2'b00}, 4'b0000, 32'h0});
        q_dout.push_back(ld_model(f3, off, rd));
      end
      do_access("b2b", we, f3, addr, rs2, rd, $urandom_range(0, 1), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_bad_access();
    test_timeout();
    test_reset_in_resp();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit of the MEM stage: turns the EX/MEM memory-access fields into a request/grant/response transaction on the data-memory port. It sign- or zero-extends load data into `MEM_dm_dataout`, which the MEM/WB register captures. It also stalls the front of the pipeline while an access is outstanding, and flags misaligned, illegal and timed-out accesses.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent waiting in REQ or RESP before aborting. Range 1..1023.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `MEM_mem_read` in 1: the instruction in MEM is a load.
- `MEM_mem_write` in 1: the instruction in MEM is a store. Never asserted together with `MEM_mem_read`.
- `MEM_func3` in 3: access type. 0=B, 1=H, 2=W, 4=BU, 5=HU. Any other value is illegal.
- `MEM_alu_result` in 32: byte address.
- `MEM_rs2_data` in 32: store data.
- `dm_req` out 1: request valid.
- `dm_we` out 1: 1=write, 0=read.
- `dm_addr` out 32: word address, `{MEM_alu_result[31:2], 2'b00}`.
- `dm_wstrb` out 4: byte write enables. 0 for reads.
- `dm_wdata` out 32: lane-replicated store data.
- `dm_gnt` in 1: request accepted this cycle.
- `dm_rvalid` in 1: read data valid.
- `dm_rdata` in 32: read word.
- `MEM_dm_dataout` out 32: extended load result.
- `lsu_stall` out 1: hold the IF/ID/EX/MEM registers this cycle.
- `lsu_done` out 1: one-cycle pulse when an access completes.
- `lsu_err` out 1: one-cycle pulse on misaligned, illegal or timed-out access.

## Operation
- States: IDLE, REQ, RESP, DONE.
- An access starts in IDLE when `MEM_mem_read | MEM_mem_write` is high.
- Alignment check:
  - H/HU/SH require `addr[0]==0`.
  - W/SW require `addr[1:0]==0`.
  - A store with func3 of 4 or 5, or any func3 outside {0,1,2,4,5}, is illegal.
- Bad access (misaligned or illegal) in IDLE:
  - No bus request is issued and `lsu_stall` stays 0.
  - Next edge: `lsu_err`=1 and `MEM_dm_dataout`=0.
  - State stays IDLE.
- Good access in IDLE:
  - `lsu_stall`=1 combinationally.
  - Next edge: state REQ, `dm_req`=1, and `dm_we`/`dm_addr`/`dm_wstrb`/`dm_wdata` registered.
- Store strobes and data:
  - SB: `wstrb = 1<<addr[1:0]`, `wdata = {4{rs2[7:0]}}`.
  - SH: `wstrb = 4'b0011<<(2*addr[1])`, `wdata = {2{rs2[15:0]}}`.
  - SW: `wstrb = 4'b1111`, `wdata = rs2`.
- REQ:
  - `dm_req` and all bus fields are held stable until `dm_gnt`.
  - On `dm_gnt`, `dm_req` drops at the next edge.
  - Store: next state DONE.
  - Load: next state RESP.
- RESP:
  - On `dm_rvalid`, the selected byte or half (by `addr[1:0]`) of `dm_rdata` is extended per func3 into `MEM_dm_dataout`.
  - Next state DONE.
- DONE:
  - `lsu_stall`=0 and `lsu_done`=1. The pipeline advances at the end of this cycle.
  - Next state is always IDLE. Memory fields on the inputs during DONE are not started as a new access.
- Timeout:
  - A 10-bit wait counter clears when entering REQ and increments every cycle spent in REQ or RESP.
  - When the counter reaches `TIMEOUT_CYCLES`, the access aborts:
    - `dm_req` is forced to 0.
    - Next edge: state DONE, with `lsu_err`=1 registered and `MEM_dm_dataout`=0.
- `dm_rvalid` is ignored in IDLE, REQ, DONE, and after reset.
- `MEM_dm_dataout` holds its value except at a load capture, an error, or reset.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `dm_req`, `dm_we`, `dm_wstrb`, `lsu_done`, `lsu_err`: 0.
  - `dm_addr`, `dm_wdata`, `MEM_dm_dataout`: 0.
  - `lsu_stall` is 0 after reset while no access is presented.
- Store with immediate grant:
  - C0 IDLE, stall=1.
  - C1 REQ, req=1, gnt=1, stall=1.
  - C2 DONE, done=1, stall=0.
- Load with immediate grant and next-cycle rvalid:
  - C0 IDLE, C1 REQ, C2 RESP (rvalid), C3 DONE.
  - `MEM_dm_dataout` is valid from C3.
- `lsu_stall` = (state==REQ) | (state==RESP) | (IDLE & good access).
- `dm_gnt` and `dm_rvalid` in the same cycle: the rvalid is ignored. Memory must return rvalid no earlier than one cycle after gnt.
- Reset mid-access: everything returns to reset values at the next edge. Any outstanding `dm_rvalid` is discarded.
- Timeout firing in the same cycle as `dm_gnt` or `dm_rvalid`: the completion takes priority and no error is raised.

## Test plan
- SW of 0xDEADBEEF to 0x100, gnt on first REQ cycle:
  - `dm_addr`=0x100, `wstrb`=4'b1111.
  - stall is high for 2 cycles, then `lsu_done`.
- SB with rs2=0x12345678 to 0x203:
  - `wstrb`=4'b1000, `wdata`=0x78787878.
- LB from 0x102 with rdata=0x0080FF00:
  - dataout=0xFFFFFF80.
  - The same access with LBU gives 0x00000080.
- LH from 0x101:
  - No `dm_req`, `lsu_err` pulses once, stall stays 0, dataout=0.
- LW with gnt never asserted and TIMEOUT_CYCLES=4:
  - `dm_req` drops after 4 REQ cycles.
  - DONE follows with `lsu_err`=1, dataout=0.
- rst asserted while in RESP, then a late `dm_rvalid`:
  - State is IDLE, dataout stays 0, and no `lsu_done` is generated.
